// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and the multiplier datapath:
// matrix geometry, packed vector width and the loader state encoding.
package matrix_pkg;

    localparam int DIM   = 5;
    localparam int EW    = 8;
    localparam int VEC_W = DIM * DIM * EW;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_loader.sv
// Streams two DIMxDIM matrices row-major and packs A by rows into lin and
// B by columns into col, then holds both stable until the consumer acks.
module matrix_loader #(
    parameter int DIM = matrix_pkg::DIM,
    parameter int EW  = matrix_pkg::EW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EW-1:0]         in_data,
    input  logic                  abort,
    output logic [DIM*DIM*EW-1:0] lin,
    output logic [DIM*DIM*EW-1:0] col,
    output logic                  mat_valid,
    input  logic                  mat_ack,
    output logic                  busy
);

    import matrix_pkg::*;

    localparam int VEC_W = DIM * DIM * EW;
    localparam int CW    = $clog2(DIM);
    localparam int IW    = $clog2(VEC_W);

    state_t         state, state_n;
    logic [CW-1:0]  row_cnt, row_n;
    logic [CW-1:0]  col_cnt, col_n;
    logic           fire;
    logic           last_elem;
    logic           wr_a, wr_b;
    logic [IW-1:0]  lin_idx, col_idx;

    assign fire      = in_valid && in_ready;
    assign last_elem = (row_cnt == CW'(DIM - 1)) && (col_cnt == CW'(DIM - 1));

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        row_n   = row_cnt;
        col_n   = col_cnt;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        lin_idx = IW'(VEC_W - 1 - (int'(row_cnt) * DIM + int'(col_cnt)) * EW);
        col_idx = IW'(VEC_W - 1 - (int'(col_cnt) * DIM + int'(row_cnt)) * EW);

        if (abort) begin
            // Abort wins over a coincident transfer or ack.
            state_n = LOAD_A;
            row_n   = '0;
            col_n   = '0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    if (fire) begin
                        wr_a = (state == LOAD_A);
                        wr_b = (state == LOAD_B);
                        if (col_cnt == CW'(DIM - 1)) begin
                            col_n = '0;
                            row_n = (row_cnt == CW'(DIM - 1)) ? '0 : row_cnt + 1'b1;
                        end else begin
                            col_n = col_cnt + 1'b1;
                        end
                        if (last_elem) begin
                            state_n = (state == LOAD_A) ? LOAD_B : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (mat_ack && mat_valid) begin
                        state_n = LOAD_A;
                    end
                end
                default: begin
                    state_n = LOAD_A;
                    row_n   = '0;
                    col_n   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_A;
            row_cnt   <= '0;
            col_cnt   <= '0;
            mat_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            row_cnt   <= row_n;
            col_cnt   <= col_n;
            mat_valid <= (state_n == HOLD);
            in_ready  <= (state_n != HOLD);
            busy      <= (state_n != LOAD_A) || (row_n != '0) || (col_n != '0);
        end
    end

    // The packed matrices are cleared on reset so consumers never see stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lin <= '0;
            col <= '0;
        end else begin
            if (wr_a) lin[lin_idx -: EW] <= in_data;
            if (wr_b) col[col_idx -: EW] <= in_data;
        end
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter DIM, default 5, meaning matrix dimension (rows = columns).
REQ-002 SHALL have parameter EW, default 8, meaning signed element width in bits.
REQ-003 SHALL use a single clock; reset SHALL be asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data carries an element.
REQ-007 SHALL have port in_ready, output, 1, meaning the loader accepts an element this cycle.
REQ-008 SHALL have port in_data, input, EW, meaning a signed element, streamed row-major: 25 A elements, then 25 B elements.
REQ-009 SHALL have port abort, input, 1, meaning synchronous discard of the partial load.
REQ-010 SHALL have port lin, output, DIM*DIM*EW (200), meaning A rows packed for the multiplier.
REQ-011 SHALL have port col, output, DIM*DIM*EW (200), meaning B columns packed for the multiplier.
REQ-012 SHALL have port mat_valid, output, 1, meaning lin/col are complete and stable.
REQ-013 SHALL have port mat_ack, input, 1, meaning the consumer has taken lin/col.
REQ-014 SHALL have port busy, output, 1, meaning a load is in progress (element count nonzero or HOLD).

Function
REQ-015 SHALL implement states LOAD_A, LOAD_B and HOLD, with registered outputs.
REQ-016 SHALL assert in_ready in LOAD_A and LOAD_B, and deassert it in HOLD.
REQ-017 SHALL transfer an element only on a rising edge where in_valid and in_ready are both 1.
REQ-018 SHALL write A(r,c) (r,c from 0) to lin[199-40r-8c -: 8] in LOAD_A.
REQ-019 SHALL write B(r,c) to col[199-40c-8r -: 8] in LOAD_B, i.e. transposed so that each 40-bit slice is one column.
REQ-020 SHALL track position with a row counter and a column counter, each wrapping 4->0, with the row counter advancing on column wrap.
REQ-021 SHALL move LOAD_A->LOAD_B on the 25th A transfer, with the counters returning to 0.
REQ-022 SHALL move LOAD_B->HOLD on the 25th B transfer, with mat_valid rising the cycle after that transfer edge.
REQ-023 SHALL hold lin/col constant while mat_valid=1.
REQ-024 SHALL, in HOLD with mat_ack=1, go to LOAD_A, clear mat_valid at the next edge, and raise in_ready in the same cycle.
REQ-025 SHALL ignore mat_ack when mat_valid=0.
REQ-026 SHALL ignore in_valid while in_ready=0; no element is consumed.
REQ-027 SHALL, on abort=1 in any state, go to LOAD_A, zero the counters and clear mat_valid at the next edge; lin/col contents are don't-care afterwards.
REQ-028 SHALL give abort precedence over a simultaneous transfer (element dropped) and over a simultaneous mat_ack.
REQ-029 SHALL have a load-to-valid latency of exactly 50 accepted transfers plus 1 cycle, with a throughput of one element per cycle.
REQ-030 SHALL never modify element values: no arithmetic, and the sign is preserved bit-exact.

Reset
REQ-031 SHALL, while rst=0, force state=LOAD_A, counters=0, lin=0, col=0, mat_valid=0, busy=0 and in_ready=0, independent of clk.
REQ-032 SHALL assert in_ready on the first rising edge after rst deasserts.
REQ-033 SHALL discard all partial progress on reset mid-load or mid-HOLD.

Structure
REQ-034 SHALL place DIM, EW, VEC_W=DIM*DIM*EW and the state enumeration in shared package matrix_pkg, reused by the multiplier datapath.
REQ-035 SHALL be a single module with no sub-modules; slice addressing is computed from the counters.

Verification
REQ-036 SHALL cover this scenario: stream A=1..25 and B=identity back-to-back -> mat_valid on cycle 51; lin[199:192]=1 and lin[7:0]=25; col[199:192]=1, col[191:184]=0 and col[159:152]=0.
REQ-037 SHALL cover this scenario: B(0,1)=0x7F, B(1,0)=0x80, all others 0 -> col[159:152]=0x7F and col[191:184]=0x80.
REQ-038 SHALL cover this scenario: random in_valid gaps over 50 elements -> same lin/col as gapless; in_ready=0 throughout HOLD; extra in_valid pulses in HOLD consumed nothing.
REQ-039 SHALL cover this scenario: hold mat_ack=0 for 10 cycles, then pulse it -> lin/col stable for 10 cycles; mat_valid=0 and in_ready=1 the next cycle.
REQ-040 SHALL cover this scenario: abort after 30 elements, coincident with in_valid -> counters=0, state LOAD_A; a fresh 50-element load yields the correct matrices.
REQ-041 SHALL cover this scenario: rst=0 asserted mid-LOAD_B between clock edges -> outputs zero immediately; in_ready=1 one edge after release.
